pmod_link: RTL and testbench



---
 rtl/link_pkg.sv | 24 ++
 rtl/link_rx_filter.sv | 39 +++
 rtl/pmod_link.sv | 123 ++++++++++++
 tb/tb_pmod_link.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/link_pkg.sv
// Shared definitions for the inter-board PMOD link: pin layout helpers and tx states.
package link_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, HOLD} tx_state_t;

  localparam int DATA_LO = 0;

  function automatic int link_w(input int dw, input int fw);
    return dw + fw + 1;
  endfunction

  function automatic int tog_pos(input int dw, input int fw);
    return dw + fw;
  endfunction

  function automatic int flag_lo(input int dw);
    return dw;
  endfunction

  function automatic int flag_hi(input int dw, input int fw);
    return dw + fw - 1;
  endfunction

endpackage

// File: rtl/link_rx_filter.sv
// Synchronises an asynchronous word and only publishes it once it has held still.
module link_rx_filter #(
  parameter int W             = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] stable_word
);

  localparam int CW = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);

  logic [SYNC_STAGES-1:0][W-1:0] sync_pipe;
  logic [W-1:0]                  s, s_prev;
  logic [CW-1:0]                 cnt;

  assign s = sync_pipe[SYNC_STAGES-1];

  // Word is copied only while it is still unchanged after the counter saturates,
  // so a change landing on the saturation edge is never captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_pipe   <= '0;
      s_prev      <= '0;
      cnt         <= '0;
      stable_word <= '0;
    end else begin
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], din};
      s_prev    <= s;
      if (s != s_prev)     cnt <= '0;
      else if (cnt != CMAX) cnt <= cnt + CW'(1);
      if (s == s_prev && cnt == CMAX) stable_word <= s;
    end
  end

endmodule

// File: rtl/pmod_link.sv
// Framed PMOD link: toggle-marked data messages plus continuous level flags, both directions.
module pmod_link
  import link_pkg::*;
#(
  parameter int DATA_W        = 5,
  parameter int FLAG_W        = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int SETUP_CYCLES  = 2,
  parameter int HOLD_CYCLES   = 8,
  localparam int LINK_W       = link_w(DATA_W, FLAG_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [FLAG_W-1:0] tx_flags,
  output logic [LINK_W-1:0] link_out,
  input  logic [LINK_W-1:0] link_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic [FLAG_W-1:0] rx_flags
);

  localparam int TOG  = tog_pos(DATA_W, FLAG_W);
  localparam int FLO  = flag_lo(DATA_W);
  localparam int FHI  = flag_hi(DATA_W, FLAG_W);
  localparam int TMAX = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] SETUP_LAST = TW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LAST  = TW'(HOLD_CYCLES - 1);

  // ---------------- transmit ----------------
  tx_state_t         state, state_n;
  logic [TW-1:0]     cnt, cnt_n;
  logic              tog, tog_n;
  logic [DATA_W-1:0] data_q, data_n;
  logic [FLAG_W-1:0] flags_q;
  logic              idle_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      tog     <= 1'b0;
      data_q  <= '0;
      flags_q <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      tog     <= tog_n;
      data_q  <= data_n;
      flags_q <= tx_flags;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    tog_n   = tog;
    data_n  = data_q;
    idle_c  = 1'b0;
    case (state)
      IDLE: begin
        idle_c = 1'b1;
        if (tx_valid) begin
          data_n  = tx_data;
          cnt_n   = '0;
          state_n = SETUP;
        end
      end
      SETUP: begin
        if (cnt == SETUP_LAST) begin
          tog_n   = ~tog;
          cnt_n   = '0;
          state_n = HOLD;
        end else cnt_n = cnt + TW'(1);
      end
      HOLD: begin
        if (cnt == HOLD_LAST) state_n = IDLE;
        else                  cnt_n   = cnt + TW'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  // Gated by rst_n so the sender never looks ready while held in reset.
  assign tx_ready = idle_c & rst_n;
  assign link_out = {tog, flags_q, data_q};

  // ---------------- receive ----------------
  logic [LINK_W-1:0] sw;
  logic              last_tog;

  link_rx_filter #(
    .W            (LINK_W),
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filt (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (link_in),
    .stable_word(sw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_flags <= '0;
      last_tog <= 1'b0;
    end else begin
      rx_flags <= sw[FHI:FLO];
      rx_valid <= (sw[TOG] != last_tog);
      if (sw[TOG] != last_tog) begin
        rx_data  <= sw[DATA_W-1:DATA_LO];
        last_tog <= sw[TOG];
      end
    end
  end

endmodule

// File: tb/tb_pmod_link.sv
// Directed bench for pmod_link: loopback messaging, glitch rejection, flag latency, reset.
module tb_pmod_link;
  import link_pkg::*;

  localparam int DW = 5;
  localparam int FW = 2;
  localparam int LW = link_w(DW, FW);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [FW-1:0] tx_flags = '0;
  logic [LW-1:0] link_out, link_in;
  logic [LW-1:0] drv = '0;
  logic          loop = 1'b1;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic [FW-1:0] rx_flags;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int pulses = 0;
  int rx_cyc = 0;
  int rx_hist[$];

  assign link_in = loop ? link_out : drv;

  pmod_link dut (
    .clk(clk), .rst_n(rst_n),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_flags(tx_flags),
    .link_out(link_out), .link_in(link_in),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_flags(rx_flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      pulses <= pulses + 1;
      rx_cyc <= cyc;
      rx_hist.push_back(int'(rx_data));
    end
  end

  task automatic wait_pulse(input int target, input int limit, output bit got);
    got = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk); #1;
      if (pulses >= target) begin got = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    #2;
    vectors++; if (tx_ready !== 1'b0) begin miscompares++; $display("FAIL rst_tx_ready got %0b want 0", tx_ready); end
    vectors++; if (link_out !== '0) begin miscompares++; $display("FAIL rst_link_out got %h want 00", link_out); end
    vectors++; if ({rx_valid, rx_data, rx_flags} !== '0) begin miscompares++; $display("FAIL rst_rx got v%0b d%0d f%0d want 0", rx_valid, rx_data, rx_flags); end
    @(negedge clk); @(negedge clk); rst_n = 1'b1; #1;
    vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL rel_tx_ready got %0b want 1", tx_ready); end
  endtask

  task automatic test_single;
    int base, acc, n;
    logic t1, t2;
    bit got;
    base = pulses; t1 = 1'bx; t2 = 1'bx; n = 0;
    @(negedge clk); tx_data = 5'd19; tx_valid = 1'b1;
    @(negedge clk); tx_valid = 1'b0; acc = cyc;
    for (int k = 0; k < 20; k++) begin
      if (k == 1) t1 = link_out[LW-1];
      if (k == 2) t2 = link_out[LW-1];
      if (tx_ready) break;
      n++;
      @(negedge clk);
    end
    vectors++; if (n !== 10) begin miscompares++; $display("FAIL single_busy got %0d want 10", n); end
    vectors++; if (t1 !== 1'b0) begin miscompares++; $display("FAIL single_tog_setup got %0b want 0", t1); end
    vectors++; if (t2 !== 1'b1) begin miscompares++; $display("FAIL single_tog_flip got %0b want 1", t2); end
    wait_pulse(base + 1, 30, got);
    vectors++; if (!got) begin miscompares++; $display("FAIL single_timeout got 0 pulses want 1"); end
    vectors++; if (rx_hist[$] !== 19) begin miscompares++; $display("FAIL single_data got %0d want 19", rx_hist[$]); end
    vectors++; if (rx_cyc - acc !== 11) begin miscompares++; $display("FAIL single_latency got %0d want 11", rx_cyc - acc); end
    repeat (15) @(negedge clk); #1;
    vectors++; if (pulses - base !== 1) begin miscompares++; $display("FAIL single_pulses got %0d want 1", pulses - base); end
  endtask

  task automatic test_back_to_back;
    int base, hb, acc1, acc2;
    bit got, got2;
    base = pulses; hb = rx_hist.size(); acc2 = -1; got2 = 1'b0;
    @(negedge clk); tx_data = 5'd7; tx_valid = 1'b1;
    @(negedge clk); acc1 = cyc; tx_data = 5'd31;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tx_ready) begin acc2 = cyc + 1; @(negedge clk); tx_valid = 1'b0; got2 = 1'b1; break; end
    end
    tx_valid = 1'b0;
    vectors++; if (!got2 || acc2 - acc1 !== 11) begin miscompares++; $display("FAIL b2b_spacing got %0d want 11", acc2 - acc1); end
    wait_pulse(base + 2, 40, got);
    vectors++; if (!got) begin miscompares++; $display("FAIL b2b_timeout got %0d pulses want 2", pulses - base); end
    vectors++; if (rx_hist.size() < hb + 2 || rx_hist[hb] !== 7) begin miscompares++; $display("FAIL b2b_first got %0d want 7", (rx_hist.size() > hb) ? rx_hist[hb] : -1); end
    vectors++; if (rx_hist.size() < hb + 2 || rx_hist[hb+1] !== 31) begin miscompares++; $display("FAIL b2b_second got %0d want 31", (rx_hist.size() > hb + 1) ? rx_hist[hb+1] : -1); end
    repeat (20) @(negedge clk); #1;
    vectors++; if (pulses - base !== 2) begin miscompares++; $display("FAIL b2b_pulses got %0d want 2", pulses - base); end
  endtask

  task automatic test_glitch;
    int base;
    @(negedge clk); drv = link_out; loop = 1'b0; base = pulses;
    @(negedge clk); drv[LW-1] = ~drv[LW-1];
    repeat (3) @(negedge clk);
    drv[LW-1] = ~drv[LW-1];
    repeat (20) @(negedge clk); #1;
    vectors++; if (pulses !== base) begin miscompares++; $display("FAIL glitch_pulses got %0d want 0", pulses - base); end
    vectors++; if (rx_data !== 5'd31) begin miscompares++; $display("FAIL glitch_data got %0d want 31", rx_data); end
    vectors++; if (rx_flags !== 2'b00) begin miscompares++; $display("FAIL glitch_flags got %b want 00", rx_flags); end
  endtask

  task automatic test_flags;
    int base;
    base = pulses;
    @(negedge clk); drv[DW+FW-1:DW] = 2'b10;
    repeat (8) @(negedge clk); #1;
    vectors++; if (rx_flags !== 2'b00) begin miscompares++; $display("FAIL flags_early got %b want 00", rx_flags); end
    @(negedge clk); #1;
    vectors++; if (rx_flags !== 2'b10) begin miscompares++; $display("FAIL flags_8cyc got %b want 10", rx_flags); end
    vectors++; if (pulses !== base) begin miscompares++; $display("FAIL flags_pulse got %0d want 0", pulses - base); end
    // Line up link_out with the driven word so returning to loopback is a non-event.
    tx_flags = 2'b10;
    repeat (3) @(negedge clk);
    loop = 1'b1;
  endtask

  task automatic test_flag_during_hold;
    int base, acc;
    bit got;
    repeat (12) @(negedge clk);
    base = pulses;
    tx_data = 5'd12; tx_valid = 1'b1;
    @(negedge clk); tx_valid = 1'b0; acc = cyc;
    repeat (4) @(negedge clk);
    tx_flags = 2'b01;
    wait_pulse(base + 1, 40, got);
    vectors++; if (!got) begin miscompares++; $display("FAIL hold_timeout got 0 pulses want 1"); end
    vectors++; if (rx_hist[$] !== 12) begin miscompares++; $display("FAIL hold_data got %0d want 12", rx_hist[$]); end
    vectors++; if (rx_cyc - acc !== 14) begin miscompares++; $display("FAIL hold_latency got %0d want 14", rx_cyc - acc); end
    repeat (15) @(negedge clk); #1;
    vectors++; if (pulses - base !== 1) begin miscompares++; $display("FAIL hold_pulses got %0d want 1", pulses - base); end
    vectors++; if (rx_flags !== 2'b01) begin miscompares++; $display("FAIL hold_flags got %b want 01", rx_flags); end
  endtask

  task automatic test_mid_reset;
    int base, acc;
    bit got;
    base = pulses;
    @(negedge clk); tx_data = 5'd3; tx_valid = 1'b1;
    @(negedge clk); tx_valid = 1'b0;
    @(negedge clk); rst_n = 1'b0; #1;
    vectors++; if (link_out !== '0) begin miscompares++; $display("FAIL mrst_link_out got %h want 00", link_out); end
    vectors++; if (tx_ready !== 1'b0) begin miscompares++; $display("FAIL mrst_tx_ready got %0b want 0", tx_ready); end
    vectors++; if ({rx_valid, rx_data, rx_flags} !== '0) begin miscompares++; $display("FAIL mrst_rx got v%0b d%0d f%b want 0", rx_valid, rx_data, rx_flags); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1; #1;
    vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL mrst_ready got %0b want 1", tx_ready); end
    base = pulses;
    tx_data = 5'd9; tx_valid = 1'b1;
    @(negedge clk); tx_valid = 1'b0; acc = cyc;
    wait_pulse(base + 1, 30, got);
    vectors++; if (!got) begin miscompares++; $display("FAIL mrst_timeout got 0 pulses want 1"); end
    vectors++; if (rx_hist[$] !== 9) begin miscompares++; $display("FAIL mrst_data got %0d want 9", rx_hist[$]); end
    vectors++; if (rx_cyc - acc !== 11) begin miscompares++; $display("FAIL mrst_latency got %0d want 11", rx_cyc - acc); end
    repeat (15) @(negedge clk); #1;
    vectors++; if (pulses - base !== 1) begin miscompares++; $display("FAIL mrst_pulses got %0d want 1", pulses - base); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_flags;
    test_flag_during_hold;
    test_mid_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
